// File: rtl/dmem_sram_pkg.sv
// dmem_sram_pkg: shared encodings and lane-steering helpers for the
// MEM-stage data memory.
package dmem_sram_pkg;

    // Access width selected by dmem_maskMode; 2'h3 is reserved and behaves as a word.
    localparam logic [1:0] MASK_BYTE = 2'h0;
    localparam logic [1:0] MASK_HALF = 2'h1;
    localparam logic [1:0] MASK_WORD = 2'h2;

    // INIT clears the array after reset; READY serves accesses until the next reset.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Byte enables for a store at the given byte lane.
    function automatic logic [3:0] store_be(input logic [1:0] mask_mode,
                                            input logic [1:0] lane);
        logic [3:0] be;
        case (mask_mode)
            MASK_BYTE: be = 4'b0001 << lane;
            MASK_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across every lane it could land in,
    // so the byte enables alone pick the destination.
    function automatic logic [31:0] store_data(input logic [1:0]  mask_mode,
                                               input logic [31:0] wd);
        logic [31:0] data;
        case (mask_mode)
            MASK_BYTE: data = {4{wd[7:0]}};
            MASK_HALF: data = {2{wd[15:0]}};
            default:   data = wd;
        endcase
        return data;
    endfunction

    // Pull the addressed lane out of a raw word and widen it to 32 bits.
    function automatic logic [31:0] load_data(input logic [1:0]  mask_mode,
                                              input logic [1:0]  lane,
                                              input logic        sext,
                                              input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(raw >> {lane, 3'b000});
        h = 16'(raw >> {lane[1], 4'b0000});
        case (mask_mode)
            MASK_BYTE: res = {{24{sext & b[7]}}, b};
            MASK_HALF: res = {{16{sext & h[15]}}, h};
            default:   res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_sram_if.sv
// dmem_sram_if: MEM-stage data bus between the access adapter (master)
// and the data memory (slave).
interface dmem_sram_if;

    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_writeData;
    logic        dmem_memRead;
    logic        dmem_memWrite;
    logic [1:0]  dmem_maskMode;
    logic        dmem_sext;
    logic [31:0] dmem_readData;
    logic        dmem_initDone;
    logic        dmem_fault;

    modport master (
        output dmem_valid, dmem_addr, dmem_writeData, dmem_memRead,
               dmem_memWrite, dmem_maskMode, dmem_sext,
        input  dmem_readData, dmem_initDone, dmem_fault
    );

    modport slave (
        input  dmem_valid, dmem_addr, dmem_writeData, dmem_memRead,
               dmem_memWrite, dmem_maskMode, dmem_sext,
        output dmem_readData, dmem_initDone, dmem_fault
    );

endinterface

// File: rtl/dmem_sram_array.sv
// dmem_sram_array: DEPTH x 32 storage with a byte-enabled synchronous
// write port and an asynchronous read port.
module dmem_sram_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Commit the enabled byte lanes of the addressed word.
    // NOTE: the storage has no reset; the owner clears it with an init sweep,
    // which keeps the array mappable onto a plain SRAM macro.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_sram.sv
// dmem_sram: single-port data memory terminating the MEM-stage bus.
// Clears itself after reset, then serves masked stores, lane-extracted
// loads with sign/zero extension, and flags misaligned or out-of-range
// accesses in a sticky fault bit.
module dmem_sram
    import dmem_sram_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    dmem_sram_if.slave dmem
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          fault_q, fault_d;

    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          oor;
    logic          mis;
    logic          is_half;
    logic          is_word;
    logic          ready;
    logic          access;
    logic          req_ok;
    logic          bad_req;

    logic          arr_we;
    logic [3:0]    arr_be;
    logic [AW-1:0] arr_waddr;
    logic [31:0]   arr_wdata;
    logic [31:0]   arr_rdata;

    // Address decode: word index, byte lane, range and alignment checks.
    assign widx    = dmem.dmem_addr[AW+1:2];
    assign lane    = dmem.dmem_addr[1:0];
    assign oor     = |dmem.dmem_addr[31:AW+2];
    assign is_half = (dmem.dmem_maskMode == MASK_HALF);
    assign is_word = dmem.dmem_maskMode[1];
    assign mis     = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    assign ready   = (state_q == READY);
    assign access  = dmem.dmem_memRead | dmem.dmem_memWrite;
    assign req_ok  = ready & dmem.dmem_valid & ~oor & ~mis;
    assign bad_req = ready & dmem.dmem_valid & access & (oor | mis);

    // State, sweep counter and sticky fault registers.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Next state: sweep one word per cycle, then hold READY until reset.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        fault_d    = fault_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_WORD) begin
                    state_d = READY;
                end
            end
            READY: begin
                fault_d = fault_q | bad_req;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Write port: the sweep owns it during INIT; afterwards only clean stores reach it.
    always_comb begin
        arr_we    = 1'b0;
        arr_be    = 4'h0;
        arr_waddr = widx;
        arr_wdata = 32'h0;
        if (!ready) begin
            arr_we    = 1'b1;
            arr_be    = 4'hF;
            arr_waddr = init_cnt_q;
        end else if (req_ok && dmem.dmem_memWrite) begin
            arr_we    = 1'b1;
            arr_be    = store_be(dmem.dmem_maskMode, lane);
            arr_wdata = store_data(dmem.dmem_maskMode, dmem.dmem_writeData);
        end
    end

    dmem_sram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .raddr_i (widx),
        .rdata_o (arr_rdata)
    );

    // Loads are combinational and read the pre-store word, so a same-cycle
    // read+write returns old data while the store commits at the edge.
    assign dmem.dmem_readData = (req_ok && dmem.dmem_memRead)
                              ? load_data(dmem.dmem_maskMode, lane, dmem.dmem_sext, arr_rdata)
                              : 32'h0;
    assign dmem.dmem_initDone = ready;
    assign dmem.dmem_fault    = fault_q;

endmodule

// File: tb/tb_dmem_sram.sv
// tb_dmem_sram: self-checking bench for dmem_sram. A 16-word instance covers
// init, data paths and alignment faults; a 1024-word instance covers range faults.
`timescale 1ns/1ps
module tb_dmem_sram;
    import dmem_sram_pkg::*;

    localparam int DEPTH_S = 16;
    localparam int DEPTH_L = 1024;

    logic clk = 1'b0;
    logic rst_s_n;
    logic rst_l_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  mask;
        logic        sext;
        logic [31:0] exp;
    } step_t;

    exp_t sb_q[$];

    dmem_sram_if bus_s();
    dmem_sram_if bus_l();

    dmem_sram #(.DEPTH(DEPTH_S)) u_dut_s (.clk(clk), .reset_n(rst_s_n), .dmem(bus_s));
    dmem_sram #(.DEPTH(DEPTH_L)) u_dut_l (.clk(clk), .reset_n(rst_l_n), .dmem(bus_l));

    always #5 clk = ~clk;

    task automatic drive_s(input logic v, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] mask, input logic sext);
        bus_s.dmem_valid     = v;
        bus_s.dmem_memRead   = rd;
        bus_s.dmem_memWrite  = wr;
        bus_s.dmem_addr      = addr;
        bus_s.dmem_writeData = wd;
        bus_s.dmem_maskMode  = mask;
        bus_s.dmem_sext      = sext;
    endtask

    task automatic drive_l(input logic v, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] mask, input logic sext);
        bus_l.dmem_valid     = v;
        bus_l.dmem_memRead   = rd;
        bus_l.dmem_memWrite  = wr;
        bus_l.dmem_addr      = addr;
        bus_l.dmem_writeData = wd;
        bus_l.dmem_maskMode  = mask;
        bus_l.dmem_sext      = sext;
    endtask

    // Drive one valid access on the small instance for a full cycle and queue its expected load result.
    task automatic apply_s(input step_t s);
        @(negedge clk);
        drive_s(1'b1, s.rd, s.wr, s.addr, s.wd, s.mask, s.sext);
        sb_q.push_back('{s.name, s.exp});
        #1;
    endtask

    // Assert reset on the small instance for two cycles, then release and wait for READY.
    task automatic restart_s();
        @(negedge clk);
        rst_s_n = 1'b0;
        drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
        repeat (2) @(negedge clk);
        rst_s_n = 1'b1;
        for (int c = 0; c < 4 * DEPTH_S && !bus_s.dmem_initDone; c++) @(negedge clk);
        tests_run++;
        if (bus_s.dmem_initDone !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_s_timeout: initDone=%b expected=1", bus_s.dmem_initDone);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_s_n = 1'b0;
        drive_s(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, MASK_WORD, 1'b0);
        #1;
        tests_run++;
        if (bus_s.dmem_initDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_initDone: got=%b expected=0", bus_s.dmem_initDone);
        end
        tests_run++;
        if (bus_s.dmem_readData !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_readData: got=%h expected=00000000", bus_s.dmem_readData);
        end
        tests_run++;
        if (bus_s.dmem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fault: got=%b expected=0", bus_s.dmem_fault);
        end
    endtask

    task automatic test_init();
        exp_t e;
        // A read+store to word 0 is held across the whole sweep; it must be ignored.
        drive_s(1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, MASK_WORD, 1'b0);
        @(negedge clk);
        rst_s_n = 1'b1;
        for (int i = 0; i < DEPTH_S; i++) begin
            #1;
            tests_run++;
            if (bus_s.dmem_initDone !== 1'b0 || bus_s.dmem_readData !== 32'h0) begin
                tests_failed++;
                $display("FAIL init_cycle[%0d]: initDone=%b readData=%h expected 0/00000000",
                         i, bus_s.dmem_initDone, bus_s.dmem_readData);
            end
            if (i == DEPTH_S - 1) drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (bus_s.dmem_initDone !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_done: got=%b expected=1", bus_s.dmem_initDone);
        end
        for (int w = 0; w < DEPTH_S; w++) begin
            apply_s('{$sformatf("zero[%0d]", w), 1'b1, 1'b0, 32'(w * 4), 32'h0, MASK_WORD, 1'b0, 32'h0});
            e = sb_q.pop_front();
            tests_run++;
            if (bus_s.dmem_readData !== e.data) begin
                tests_failed++;
                $display("FAIL %s: readData=%h expected=%h", e.name, bus_s.dmem_readData, e.data);
            end
        end
    endtask

    task automatic test_byte();
        step_t st[7];
        exp_t  e;
        st = '{
            '{"st_word10",   1'b0, 1'b1, 32'h10, 32'h8899AABB, MASK_WORD, 1'b0, 32'h0},
            '{"st_byte12",   1'b0, 1'b1, 32'h12, 32'hFFFFFF5C, MASK_BYTE, 1'b0, 32'h0},
            '{"ld_word10",   1'b1, 1'b0, 32'h10, 32'h0,        MASK_WORD, 1'b0, 32'h885CAABB},
            '{"ld_b13_sext", 1'b1, 1'b0, 32'h13, 32'h0,        MASK_BYTE, 1'b1, 32'hFFFFFF88},
            '{"ld_b13_zext", 1'b1, 1'b0, 32'h13, 32'h0,        MASK_BYTE, 1'b0, 32'h00000088},
            '{"ld_b10_sext", 1'b1, 1'b0, 32'h10, 32'h0,        MASK_BYTE, 1'b1, 32'hFFFFFFBB},
            '{"ld_h12_zext", 1'b1, 1'b0, 32'h12, 32'h0,        MASK_HALF, 1'b0, 32'h0000885C}
        };
        foreach (st[i]) begin
            apply_s(st[i]);
            e = sb_q.pop_front();
            tests_run++;
            if (bus_s.dmem_readData !== e.data) begin
                tests_failed++;
                $display("FAIL %s: readData=%h expected=%h", e.name, bus_s.dmem_readData, e.data);
            end
        end
    endtask

    task automatic test_half();
        step_t st[7];
        exp_t  e;
        st = '{
            '{"st_half22",   1'b0, 1'b1, 32'h22, 32'h1234F00D, MASK_HALF, 1'b0, 32'h0},
            '{"ld_word20",   1'b1, 1'b0, 32'h20, 32'h0,        MASK_WORD, 1'b0, 32'hF00D0000},
            '{"ld_h22_sext", 1'b1, 1'b0, 32'h22, 32'h0,        MASK_HALF, 1'b1, 32'hFFFFF00D},
            '{"ld_h20_sext", 1'b1, 1'b0, 32'h20, 32'h0,        MASK_HALF, 1'b1, 32'h00000000},
            '{"st_half20",   1'b0, 1'b1, 32'h20, 32'h00007ABC, MASK_HALF, 1'b0, 32'h0},
            '{"ld_word20b",  1'b1, 1'b0, 32'h20, 32'h0,        MASK_WORD, 1'b0, 32'hF00D7ABC},
            '{"ld_h20_pos",  1'b1, 1'b0, 32'h20, 32'h0,        MASK_HALF, 1'b1, 32'h00007ABC}
        };
        foreach (st[i]) begin
            apply_s(st[i]);
            e = sb_q.pop_front();
            tests_run++;
            if (bus_s.dmem_readData !== e.data) begin
                tests_failed++;
                $display("FAIL %s: readData=%h expected=%h", e.name, bus_s.dmem_readData, e.data);
            end
        end
    endtask

    task automatic test_rmw();
        step_t st[5];
        exp_t  e;
        st = '{
            '{"rmw_read_old",  1'b1, 1'b0, 32'h10, 32'h0,        MASK_WORD, 1'b0, 32'h885CAABB},
            '{"rmw_store_b",   1'b0, 1'b1, 32'h10, 32'h00000011, MASK_BYTE, 1'b0, 32'h0},
            '{"rmw_read_new",  1'b1, 1'b0, 32'h10, 32'h0,        MASK_WORD, 1'b0, 32'h885CAA11},
            '{"rw_same_cycle", 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, MASK_WORD, 1'b0, 32'h885CAA11},
            '{"rw_after",      1'b1, 1'b0, 32'h10, 32'h0,        MASK_WORD, 1'b0, 32'hDEADBEEF}
        };
        foreach (st[i]) begin
            apply_s(st[i]);
            e = sb_q.pop_front();
            tests_run++;
            if (bus_s.dmem_readData !== e.data) begin
                tests_failed++;
                $display("FAIL %s: readData=%h expected=%h", e.name, bus_s.dmem_readData, e.data);
            end
        end
        @(negedge clk);
        drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
    endtask

    task automatic test_fault_mis();
        restart_s();
        #1;
        tests_run++;
        if (bus_s.dmem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_pre_fault: got=%b expected=0", bus_s.dmem_fault);
        end
        // Misaligned half store and load with valid low: no fault.
        drive_s(1'b0, 1'b0, 1'b1, 32'h21, 32'hBEEFBEEF, MASK_HALF, 1'b0);
        @(negedge clk);
        drive_s(1'b0, 1'b1, 1'b0, 32'h21, 32'h0, MASK_HALF, 1'b0);
        #1;
        tests_run++;
        if (bus_s.dmem_readData !== 32'h0) begin
            tests_failed++;
            $display("FAIL mis_novalid_rd: readData=%h expected=00000000", bus_s.dmem_readData);
        end
        @(negedge clk);
        drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
        #1;
        tests_run++;
        if (bus_s.dmem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_novalid_fault: got=%b expected=0", bus_s.dmem_fault);
        end
        // Real misaligned half store.
        @(negedge clk);
        drive_s(1'b1, 1'b0, 1'b1, 32'h21, 32'hBEEFBEEF, MASK_HALF, 1'b0);
        @(negedge clk);
        drive_s(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, MASK_WORD, 1'b0);
        #1;
        tests_run++;
        if (bus_s.dmem_fault !== 1'b1) begin
            tests_failed++;
            $display("FAIL mis_fault_set: got=%b expected=1", bus_s.dmem_fault);
        end
        tests_run++;
        if (bus_s.dmem_readData !== 32'h0) begin
            tests_failed++;
            $display("FAIL mis_no_write: word20=%h expected=00000000", bus_s.dmem_readData);
        end
        // A clean access afterwards leaves the fault sticky.
        @(negedge clk);
        drive_s(1'b1, 1'b0, 1'b1, 32'h24, 32'h01020304, MASK_WORD, 1'b0);
        @(negedge clk);
        drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
        #1;
        tests_run++;
        if (bus_s.dmem_fault !== 1'b1) begin
            tests_failed++;
            $display("FAIL mis_sticky: got=%b expected=1", bus_s.dmem_fault);
        end
    endtask

    task automatic test_fault_oor();
        @(negedge clk);
        rst_l_n = 1'b1;
        for (int c = 0; c < 2 * DEPTH_L && !bus_l.dmem_initDone; c++) @(negedge clk);
        tests_run++;
        if (bus_l.dmem_initDone !== 1'b1 || bus_l.dmem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_ready: initDone=%b fault=%b expected 1/0", bus_l.dmem_initDone, bus_l.dmem_fault);
        end
        // Seed word 0 so an ungated out-of-range read would alias to nonzero data.
        drive_l(1'b1, 1'b0, 1'b1, 32'h0, 32'h13579BDF, MASK_WORD, 1'b0);
        @(negedge clk);
        drive_l(1'b0, 1'b1, 1'b0, 32'h4002, 32'h0, MASK_WORD, 1'b0);
        #1;
        tests_run++;
        if (bus_l.dmem_readData !== 32'h0) begin
            tests_failed++;
            $display("FAIL oor_novalid_rd: readData=%h expected=00000000", bus_l.dmem_readData);
        end
        @(negedge clk);
        drive_l(1'b1, 1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, MASK_WORD, 1'b0);
        #1;
        tests_run++;
        if (bus_l.dmem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_novalid_fault: got=%b expected=0", bus_l.dmem_fault);
        end
        @(negedge clk);
        drive_l(1'b1, 1'b1, 1'b0, 32'hFFC, 32'h0, MASK_WORD, 1'b0);
        #1;
        tests_run++;
        if (bus_l.dmem_readData !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL oor_last_word: readData=%h expected=cafef00d", bus_l.dmem_readData);
        end
        @(negedge clk);
        drive_l(1'b1, 1'b1, 1'b0, 32'h4002, 32'h0, MASK_WORD, 1'b0);
        #1;
        tests_run++;
        if (bus_l.dmem_readData !== 32'h0 || bus_l.dmem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_4002_rd: readData=%h fault=%b expected 00000000/0",
                     bus_l.dmem_readData, bus_l.dmem_fault);
        end
        @(negedge clk);
        drive_l(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, MASK_WORD, 1'b0);
        #1;
        tests_run++;
        if (bus_l.dmem_fault !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_fault_set: got=%b expected=1", bus_l.dmem_fault);
        end
        tests_run++;
        if (bus_l.dmem_readData !== 32'h0) begin
            tests_failed++;
            $display("FAIL oor_4000_rd: readData=%h expected=00000000", bus_l.dmem_readData);
        end
        @(negedge clk);
        drive_l(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cycles;
        exp_t e;
        // Put nonzero data at both ends of the array.
        apply_s('{"mid_st0",  1'b0, 1'b1, 32'h00, 32'h12345678, MASK_WORD, 1'b0, 32'h0});
        void'(sb_q.pop_front());
        apply_s('{"mid_st15", 1'b0, 1'b1, 32'h3C, 32'h9ABCDEF0, MASK_WORD, 1'b0, 32'h0});
        void'(sb_q.pop_front());
        @(negedge clk);
        drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
        rst_s_n = 1'b0;
        @(negedge clk);
        rst_s_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_s_n = 1'b0;
        #1;
        tests_run++;
        if (bus_s.dmem_initDone !== 1'b0 || bus_s.dmem_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_state: initDone=%b fault=%b expected 0/0",
                     bus_s.dmem_initDone, bus_s.dmem_fault);
        end
        @(negedge clk);
        rst_s_n = 1'b1;
        cycles = 0;
        while (!bus_s.dmem_initDone && cycles < 4 * DEPTH_S) begin
            @(negedge clk);
            cycles++;
        end
        tests_run++;
        if (cycles !== DEPTH_S) begin
            tests_failed++;
            $display("FAIL mid_sweep_len: cycles=%0d expected=%0d", cycles, DEPTH_S);
        end
        apply_s('{"mid_word0",  1'b1, 1'b0, 32'h00, 32'h0, MASK_WORD, 1'b0, 32'h0});
        e = sb_q.pop_front();
        tests_run++;
        if (bus_s.dmem_readData !== e.data) begin
            tests_failed++;
            $display("FAIL %s: readData=%h expected=%h", e.name, bus_s.dmem_readData, e.data);
        end
        apply_s('{"mid_word15", 1'b1, 1'b0, 32'h3C, 32'h0, MASK_WORD, 1'b0, 32'h0});
        e = sb_q.pop_front();
        tests_run++;
        if (bus_s.dmem_readData !== e.data) begin
            tests_failed++;
            $display("FAIL %s: readData=%h expected=%h", e.name, bus_s.dmem_readData, e.data);
        end
        @(negedge clk);
        drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
    endtask

    initial begin
        rst_s_n = 1'b0;
        rst_l_n = 1'b0;
        drive_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
        drive_l(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MASK_BYTE, 1'b0);
        test_reset();
        test_init();
        test_byte();
        test_half();
        test_rmw();
        test_fault_mis();
        test_fault_oor();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
